// File: rtl/rho_scheduler.sv
`timescale 1ns/1ps
// rho_scheduler
// ---------------------------------------------------------------------------
// Purpose:
//   Time-shares one rho (Gaussian likelihood) datapath across the NUM_GAUSS
//   mixture components of a single pixel. A pixel's grey value and
//   per-component sigma/mean are captured on accept. One datapath evaluation
//   is issued per component, in order 0..NUM_GAUSS-1. The collected results
//   are then presented downstream as one set.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising clk_i edge where valid and ready are both
//   high. The producer holds valid and its payload stable until that edge.
//   The consumer may change ready at any time. Upstream uses
//   pix_valid_i/pix_ready_o. Downstream uses out_valid_o/out_ready_i.
//   The datapath side is not a handshake. rho_en_o is a one-cycle start
//   pulse, and rho_done_i is a one-cycle result pulse.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   pix_valid_i/pix_ready_o pixel accept handshake
//   grey_i, sigma_i, mu_i   pixel operands (component k at [32k+31:32k])
//   rho_en_o                start pulse to the datapath
//   rho_grey_o, rho_sigma_o, rho_mugrey_o  operands of the component in flight
//   rho_done_i, rho_result_i               datapath result pulse and value
//   rho_out_o               collected results, same packing as sigma_i
//   out_valid_o/out_ready_i result set handshake
//   comp_idx_o              component currently in flight
//   busy_o                  high whenever the FSM is not IDLE
//   dbg_state_o             raw FSM state, for checkers
//   timeout_err_o           per-component timeout flags (only with the macro)
//
// Optional feature (macro RHO_SCHED_TIMEOUT_EN):
//   This adds a WAIT watchdog of TIMEOUT_CYC cycles. On expiry the component
//   gets +0.0 and its sticky bit in timeout_err_o is set. Without the macro,
//   WAIT waits indefinitely and the port does not exist.
// ---------------------------------------------------------------------------
module rho_scheduler #(
  parameter int NUM_GAUSS   = 3,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pix_valid_i,
  output logic                   pix_ready_o,
  input  logic [31:0]            grey_i,
  input  logic [32*NUM_GAUSS-1:0] sigma_i,
  input  logic [32*NUM_GAUSS-1:0] mu_i,
  output logic                   rho_en_o,
  output logic [31:0]            rho_grey_o,
  output logic [31:0]            rho_sigma_o,
  output logic [31:0]            rho_mugrey_o,
  input  logic                   rho_done_i,
  input  logic [31:0]            rho_result_i,
  output logic [32*NUM_GAUSS-1:0] rho_out_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [IDX_W-1:0]       comp_idx_o,
  output logic                   busy_o,
  output logic [1:0]             dbg_state_o
`ifdef RHO_SCHED_TIMEOUT_EN
  ,
  output logic [NUM_GAUSS-1:0]   timeout_err_o
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GAUSS - 1);

  logic [1:0]              state;
  logic [IDX_W-1:0]        comp_idx;
  logic [31:0]             grey_q;
  logic [32*NUM_GAUSS-1:0] sigma_q;
  logic [32*NUM_GAUSS-1:0] mu_q;
  logic [32*NUM_GAUSS-1:0] rho_q;

  // The current slot finishes when a result arrives or the watchdog expires.
  logic        timeout_hit;
  logic        slot_wr;
  logic [31:0] slot_val;

`ifdef RHO_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]     wait_cnt;
  logic [NUM_GAUSS-1:0] err_q;
`endif

  always_comb begin
    timeout_hit = 1'b0;
`ifdef RHO_SCHED_TIMEOUT_EN
    // The counter is 0 in the first WAIT cycle. It expires in the
    // TIMEOUT_CYC-th WAIT cycle.
    timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif
    slot_wr  = (state == S_WAIT) && (rho_done_i || timeout_hit);
    // A done arriving in the same cycle as the terminal count wins.
    slot_val = rho_done_i ? rho_result_i : 32'h0000_0000;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      comp_idx <= '0;
      grey_q   <= '0;
      sigma_q  <= '0;
      mu_q     <= '0;
      rho_q    <= '0;
`ifdef RHO_SCHED_TIMEOUT_EN
      wait_cnt <= '0;
      err_q    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pix_valid_i) begin
            grey_q   <= grey_i;
            sigma_q  <= sigma_i;
            mu_q     <= mu_i;
            comp_idx <= '0;
            state    <= S_ISSUE;
`ifdef RHO_SCHED_TIMEOUT_EN
            err_q    <= '0;
`endif
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef RHO_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (slot_wr) begin
            for (int k = 0; k < NUM_GAUSS; k++) begin
              if (comp_idx == IDX_W'(k)) begin
                rho_q[32*k +: 32] <= slot_val;
`ifdef RHO_SCHED_TIMEOUT_EN
                if (!rho_done_i) err_q[k] <= 1'b1;
`endif
              end
            end
            if (comp_idx == LAST_IDX) begin
              state <= S_OUTPUT;
            end else begin
              comp_idx <= comp_idx + 1'b1;
              state    <= S_ISSUE;
            end
          end
`ifdef RHO_SCHED_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_OUTPUT: begin
          if (out_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand selection for the component in flight.
  always_comb begin
    rho_sigma_o  = '0;
    rho_mugrey_o = '0;
    for (int k = 0; k < NUM_GAUSS; k++) begin
      if (comp_idx == IDX_W'(k)) begin
        rho_sigma_o  = sigma_q[32*k +: 32];
        rho_mugrey_o = mu_q[32*k +: 32];
      end
    end
  end

  assign rho_grey_o  = grey_q;
  assign rho_en_o    = (state == S_ISSUE);
  assign pix_ready_o = (state == S_IDLE);
  assign out_valid_o = (state == S_OUTPUT);
  assign busy_o      = (state != S_IDLE);
  assign comp_idx_o  = comp_idx;
  assign rho_out_o   = rho_q;
  assign dbg_state_o = state;
`ifdef RHO_SCHED_TIMEOUT_EN
  assign timeout_err_o = err_q;
`endif

endmodule

// File: doc/rho_scheduler.md
Name: rho_scheduler

Overview:
- Sequences one shared rho datapath (Gaussian likelihood unit) across NUM_GAUSS mixture components of a single pixel.
- Accepts a pixel's grey value plus per-component sigma/mean. Issues one rho evaluation per component in order. Collects the results.
- Presents all NUM_GAUSS rho values to the match/update stage with a valid/ready handshake.
- Sits between the pixel/parameter fetch stage and the GMM match logic.

Parameters:
- NUM_GAUSS, 3, number of mixture components per pixel (2..8).
- IDX_W, 3, width of comp_idx_o; must satisfy 2**IDX_W >= NUM_GAUSS.
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only when RHO_SCHED_TIMEOUT_EN is defined).

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous reset, active high.
- pix_valid_i  in  1  upstream pixel/parameter set is valid.
- pix_ready_o  out  1  scheduler can accept a pixel.
- grey_i  in  32  pixel grey value, IEEE-754 single precision.
- sigma_i  in  32*NUM_GAUSS  per-component sigma; component k is at bits [32k+31:32k].
- mu_i  in  32*NUM_GAUSS  per-component mean, same packing as sigma_i.
- rho_en_o  out  1  one-cycle start pulse to the rho datapath.
- rho_grey_o  out  32  grey operand to the datapath.
- rho_sigma_o  out  32  sigma operand for the current component.
- rho_mugrey_o  out  32  mean operand for the current component.
- rho_done_i  in  1  datapath result valid (single-cycle pulse).
- rho_result_i  in  32  datapath result.
- rho_out_o  out  32*NUM_GAUSS  collected rho values, same packing as sigma_i.
- out_valid_o  out  1  rho_out_o holds a complete set.
- out_ready_i  in  1  downstream consumes the set.
- comp_idx_o  out  IDX_W  component currently in flight.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_i=1): state=IDLE; pix_ready_o=1; rho_en_o=0; out_valid_o=0; comp_idx_o=0; busy_o=0. All operand registers and rho_out_o cleared to 0. Asserting reset mid-operation aborts the operation. A rho_done_i arriving after reset release while in IDLE is ignored.
- State machine: IDLE, ISSUE, WAIT, OUTPUT.
  - IDLE: pix_ready_o=1. On pix_valid_i & pix_ready_o, register grey_i, sigma_i and mu_i into local buffers, set comp_idx=0, go to ISSUE. Later changes on the inputs have no effect.
  - ISSUE: rho_en_o=1 for exactly this cycle. rho_*_o are driven from the buffered operands of comp_idx. Next state is WAIT.
  - WAIT: rho_en_o=0. Operands stay stable until rho_done_i. On rho_done_i, write rho_result_i into slot comp_idx of rho_out_o.
    - If comp_idx == NUM_GAUSS-1, go to OUTPUT.
    - Otherwise increment comp_idx and go to ISSUE.
  - OUTPUT: out_valid_o=1 and rho_out_o stable. When out_valid_o & out_ready_i, go to IDLE and drop out_valid_o the next cycle. out_ready_i held low stalls indefinitely.
- rho_done_i is sampled only in WAIT. A pulse in IDLE, ISSUE or OUTPUT is ignored and changes no state.
- Per-pixel latency: 1 accept cycle + NUM_GAUSS × (1 ISSUE + datapath latency L) cycles to out_valid_o. The minimum is L=1, which gives done in the cycle after ISSUE.
- pix_ready_o is low in ISSUE, WAIT and OUTPUT. There is no overlap between pixels.
- Ordering: components are always evaluated in order 0..NUM_GAUSS-1 with no skipping.
- comp_idx never exceeds NUM_GAUSS-1 and does not wrap during a pixel.
- The scheduler does no arithmetic on operand values; it passes them through bit-exact.

Optional Feature:
- Macro: RHO_SCHED_TIMEOUT_EN.
- Defined:
  - Adds a counter that clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without rho_done_i, write 32'h00000000 (rho = +0.0) into slot comp_idx and set a sticky bit for that component. Then proceed exactly as if done had arrived.
  - Adds output port timeout_err_o [NUM_GAUSS-1:0] holding the sticky bits. It is valid with out_valid_o and is cleared on the next pixel accept and on reset.
  - A done that coincides with the terminal count has priority: the result is stored and no error bit is set.
- Undefined: no counter and no timeout_err_o port; WAIT waits indefinitely.

Test Plan:
- Reset then idle: after reset, pix_ready_o=1, out_valid_o=0, busy_o=0. Pulse rho_done_i in IDLE: no state change and rho_out_o stays 0.
- Nominal, NUM_GAUSS=3, datapath model L=5:
  - Stimulus: accept grey=0x42C80000; the model returns 0x3F000000, 0x3E800000, 0x3E000000.
  - Response: exactly 3 rho_en_o pulses, with rho_sigma_o/rho_mugrey_o matching slots 0, 1, 2 in order.
  - out_valid_o rises at cycle 1+3×6=19 after accept; rho_out_o = {0x3E000000, 0x3E800000, 0x3F000000}.
- Backpressure: hold out_ready_i=0 for 10 cycles. out_valid_o and rho_out_o stay stable, pix_valid_i is not accepted, and state returns to IDLE one cycle after out_ready_i=1.
- Input isolation: change sigma_i/mu_i/grey_i every cycle after accept. The datapath operands still equal the values captured at accept.
- Reset mid-WAIT (comp_idx=1): assert rst_i asynchronously. Outputs return to reset values immediately, and a subsequent late rho_done_i is ignored.
- Timeout (macro defined, TIMEOUT_CYC=20): the model never answers component 1. After 20 WAIT cycles slot 1 = 0x00000000 and timeout_err_o=3'b010. Components 0 and 2 complete normally.
